sync_fifo_param: RTL

Parametrised synchronous FIFO, the successor to the team's fixed 8-bit/10-entry FIFO. It adds configurable width and depth, concurrent push and pop in the same cycle, an exact occupancy count, and programmable almost-full/almost-empty thresholds. It sits between single-clock producers and consumers, for example UART RX buffering or sample staging, where both sides run on `clk`.

---
 rtl/sync_fifo_param.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO.
// WIDTH x DEPTH storage (any DEPTH >= 2), exact occupancy count,
// registered full/empty/almost_full/almost_empty flags and registered read data.
// Optional sticky overflow/underflow error flags are built only when the
// macro SYNC_FIFO_ERR_EN is defined; otherwise rejected requests are ignored.
//
// Handshake: push is accepted in a cycle iff (push && !full); pop is accepted
// iff (pop && !empty). Both decisions use the flag values registered at the
// start of the cycle, so a full FIFO can pop while it rejects a push, and an
// empty FIFO can accept a push while it rejects a pop. An accepted pop
// presents its word on data_out with a one-cycle data_valid pulse after the
// next rising edge of clk.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_THR   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_THR   = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             af_q, af_d;
  logic             ae_q, ae_d;
  logic             push_ok, pop_ok;

  // Accept decisions, pointer wrap, count update and next-state flags.
  always_comb begin
    push_ok      = push && !full_q;
    pop_ok       = pop && !empty_q;
    wp_d         = wp_q;
    rp_d         = rp_q;
    count_d      = count_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;

    // Pointers wrap by compare so non-power-of-two depths work.
    if (push_ok) begin
      wp_d = (wp_q == PTR_LAST) ? '0 : wp_q + PW'(1);
    end
    if (pop_ok) begin
      rp_d         = (rp_q == PTR_LAST) ? '0 : rp_q + PW'(1);
      data_out_d   = mem_q[rp_q];
      data_valid_d = 1'b1;
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Flags are derived from the next count so they line up with count.
    full_d  = (count_d == CNT_MAX);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_THR);
    ae_d    = (count_d <= AE_THR);
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q         <= '0;
      rp_q         <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      af_q         <= 1'b0;
      ae_q         <= 1'b1;
    end else begin
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      af_q         <= af_d;
      ae_q         <= ae_d;
    end
  end

  // Storage write; contents are never cleared, only overwritten.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem_q[wp_q] <= data_in;
    end
  end

  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags: set on a request against a full/empty FIFO.
  always_comb begin
    overflow_d  = overflow_q || (push && full_q);
    underflow_d = underflow_q || (pop && empty_q);
  end

  // Error flag registers, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule
